fc_argmax_collector: RTL and testbench
======================================

# fc_argmax_collector

Classification back-end that sits directly downstream of the fully-connected output of the CNN top level. It consumes the signed per-neuron scores the final FC layer emits as `LanesPerBeat` lanes per valid beat over `BeatsPerImage` beats, keeps a running maximum, and presents one class index per image on a valid/ready handshake. It decouples the stall-free FC pipeline from a possibly slow consumer through a single-entry result register with sticky overflow reporting.

## Interface
- `BitSize`, 32: width of each signed two's-complement score lane.
- `LanesPerBeat`, 2: scores per input beat (FC output width divided by its depth).
- `BeatsPerImage`, 4: beats forming one image's complete score set.
- Derived: `NumClasses = LanesPerBeat*BeatsPerImage`; `CW = max(1, $clog2(NumClasses))`.

- `clk`, in, 1: clock; all state on rising edge.
- `res_n`, in, 1: reset, asynchronous assert, active-low.
- `in_valid`, in, 1: beat of scores present (no back-pressure; always accepted).
- `in_data`, in, `[LanesPerBeat-1:0][BitSize-1:0]`: scores; lane `l` of beat `b` is class `b*LanesPerBeat+l`.
- `in_clear`, in, 1: synchronous abort of partial image and clear of `out_overflow`.
- `out_ready`, in, 1: consumer accepts result.
- `out_valid`, out, 1: result register holds an unaccepted result.
- `out_class`, out, CW: winning class index.
- `out_max`, out, BitSize: winning score (signed).
- `out_overflow`, out, 1: sticky; an image completed while the result register was full and its result was dropped.
- `out_margin`, out, BitSize: unsigned (max − second max); present only with `FC_ARGMAX_MARGIN_EN`.

## Operation
- Accumulator: `beat_cnt` (0..BeatsPerImage-1), `run_max`, `run_idx` (plus `run_second` with margin). Collection states: `IDLE` (beat_cnt=0, nothing held), `COLLECT` (≥1 beat absorbed).
- Each `in_valid` beat: lanes are compared combinationally against the running values, signed; strictly-greater replaces, so ties resolve to the lowest class index, across lanes and beats.
- First beat of an image seeds from lane data alone; no prior image's values leak.
- Final beat (beat_cnt == BeatsPerImage-1 with in_valid): the combined result is written to the result register if it is empty or is being accepted that same cycle; otherwise it is dropped and `out_overflow` is set. Accumulator returns to `IDLE`, and `beat_cnt` wraps to 0.
- `BeatsPerImage == 1`: every beat is a complete image.
- Result register: `out_valid` rises on load and falls on the cycle after `out_valid && out_ready` unless a new result loads at the same edge, in which case `out_valid` stays high with new data.
- Output data is stable while `out_valid && !out_ready`.
- `in_clear`: beat_cnt←0, accumulator→`IDLE`, `out_overflow`←0. The result register is untouched. If `in_clear` and `in_valid` coincide, the clear wins and the beat is discarded.
- Reset values: `out_valid`=0, `out_class`=0, `out_max`=0, `out_overflow`=0, `out_margin`=0, beat_cnt=0, state `IDLE`. Reset mid-image discards the partial image.

## Timing
- Latency: final beat sampled at edge N, so `out_valid`/`out_class` are visible after edge N (one cycle).
- Throughput: one beat per cycle sustained. Back-to-back images are accepted with no bubble.
- Combinational depth: `LanesPerBeat`-way signed compare tree plus merge with running value, all in one cycle.
- `out_ready` has no combinational path to any output.

## Configuration
- `FC_ARGMAX_MARGIN_EN` defined: tracks the running second-highest score (duplicates of the max count, so equal top scores give margin 0). `out_margin` = max − second, computed as an unsigned BitSize-bit value and registered with the result. With `NumClasses == 1`, margin is 0.
- Undefined: no second-max logic and no `out_margin` port. All other behaviour is identical.

## Test plan
- Reset/idle: hold `res_n`=0, then release with no input -> all outputs 0, `out_valid` stays 0.
- Single image, defaults: beats {5,−3},{7,2},{−8,7},{1,0} with out_ready=1 -> one cycle after beat 4, `out_valid`=1 for one cycle, `out_class`=2, `out_max`=7 (tie with class 5 resolves low), `out_margin`=0.
- Negative scores: all lanes −10 except class 6 = −2 -> `out_class`=6, `out_max`=−2, `out_margin`=8.
- Back-pressure/overflow: out_ready=0, two complete images streamed back-to-back -> first result held stable, `out_overflow`=1 after the second image's last beat. `in_clear` clears overflow but `out_valid` stays 1.
- Simultaneous accept and load: out_ready pulsed on the same cycle the second image's result loads -> `out_valid` stays 1 and shows the second result, overflow stays 0.
- Abort: 2 beats, then `in_clear` together with `in_valid`, then 4 fresh beats -> exactly one result, from the fresh beats only. Asserting `res_n`=0 mid-image gives the same outcome.

Source files
------------

// File: rtl/fc_argmax_collector.sv
// Running signed argmax over a multi-beat FC score stream, delivered through a
// single-entry result register. Define FC_ARGMAX_MARGIN_EN for second-max tracking and out_margin.
module fc_argmax_collector #(
    parameter int  BitSize       = 32,
    parameter int  LanesPerBeat  = 2,
    parameter int  BeatsPerImage = 4,
    localparam int NumClasses    = LanesPerBeat * BeatsPerImage,
    localparam int CW            = (NumClasses > 1) ? $clog2(NumClasses) : 1
) (
    input  logic                                 clk,
    input  logic                                 res_n,
    input  logic                                 in_valid,
    input  logic [LanesPerBeat-1:0][BitSize-1:0] in_data,
    input  logic                                 in_clear,
    input  logic                                 out_ready,
    output logic                                 out_valid,
    output logic [CW-1:0]                        out_class,
    output logic [BitSize-1:0]                   out_max,
`ifdef FC_ARGMAX_MARGIN_EN
    output logic [BitSize-1:0]                   out_margin,
`endif
    output logic                                 out_overflow
);

    localparam int BCW = (BeatsPerImage > 1) ? $clog2(BeatsPerImage) : 1;
    localparam logic [BCW-1:0] LastBeat = BCW'(BeatsPerImage - 1);

    typedef enum logic {IDLE, COLLECT} state_e;

    state_e                    state_q, state_d;
    logic [BCW-1:0]            beatCnt_q, beatCnt_d;
    logic signed [BitSize-1:0] runMax_q, runMax_d;
    logic [CW-1:0]             runIdx_q, runIdx_d;
    logic                      outValid_q, outValid_d;
    logic [CW-1:0]             outClass_q, outClass_d;
    logic [BitSize-1:0]        outMax_q, outMax_d;
    logic                      outOverflow_q, outOverflow_d;

    logic signed [BitSize-1:0] mergeMax, laneScore;
    logic [CW-1:0]             mergeIdx, laneIdx;
    logic                      beatTaken, lastBeat, loadResult;

`ifdef FC_ARGMAX_MARGIN_EN
    localparam logic signed [BitSize-1:0] MinScore = {1'b1, {(BitSize-1){1'b0}}};
    logic signed [BitSize-1:0] runSecond_q, runSecond_d, mergeSecond;
    logic [BitSize-1:0]        outMargin_q, outMargin_d, mergeMargin;
`endif

    // In IDLE lane 0 seeds the merge so nothing from the previous image leaks in;
    // strict greater-than keeps ties on the lowest class index.
    always_comb begin
        mergeMax  = runMax_q;
        mergeIdx  = runIdx_q;
        laneScore = '0;
        laneIdx   = '0;
`ifdef FC_ARGMAX_MARGIN_EN
        mergeSecond = runSecond_q;
`endif
        if (state_q == IDLE) begin
            mergeMax = $signed(in_data[0]);
            mergeIdx = '0;
`ifdef FC_ARGMAX_MARGIN_EN
            mergeSecond = MinScore;
`endif
        end
        for (int l = 0; l < LanesPerBeat; l++) begin
            laneScore = $signed(in_data[l]);
            laneIdx   = CW'(int'(beatCnt_q) * LanesPerBeat + l);
            if (state_q != IDLE || l != 0) begin
                if (laneScore > mergeMax) begin
`ifdef FC_ARGMAX_MARGIN_EN
                    mergeSecond = mergeMax;
`endif
                    mergeMax = laneScore;
                    mergeIdx = laneIdx;
                end
`ifdef FC_ARGMAX_MARGIN_EN
                else if (laneScore > mergeSecond) begin
                    mergeSecond = laneScore;
                end
`endif
            end
        end
    end

`ifdef FC_ARGMAX_MARGIN_EN
    assign mergeMargin = (NumClasses == 1) ? '0 : BitSize'(mergeMax - mergeSecond);
`endif

    assign beatTaken  = in_valid && !in_clear;
    assign lastBeat   = beatTaken && (beatCnt_q == LastBeat);
    assign loadResult = lastBeat && (!outValid_q || out_ready);

    always_comb begin
        state_d       = state_q;
        beatCnt_d     = beatCnt_q;
        runMax_d      = runMax_q;
        runIdx_d      = runIdx_q;
        outValid_d    = outValid_q;
        outClass_d    = outClass_q;
        outMax_d      = outMax_q;
        outOverflow_d = outOverflow_q;
`ifdef FC_ARGMAX_MARGIN_EN
        runSecond_d = runSecond_q;
        outMargin_d = outMargin_q;
`endif
        if (in_clear) begin
            state_d       = IDLE;
            beatCnt_d     = '0;
            outOverflow_d = 1'b0;
        end else if (in_valid) begin
            runMax_d = mergeMax;
            runIdx_d = mergeIdx;
`ifdef FC_ARGMAX_MARGIN_EN
            runSecond_d = mergeSecond;
`endif
            if (lastBeat) begin
                state_d   = IDLE;
                beatCnt_d = '0;
                if (!loadResult) begin
                    outOverflow_d = 1'b1;
                end
            end else begin
                state_d   = COLLECT;
                beatCnt_d = beatCnt_q + BCW'(1);
            end
        end

        // A load at the same edge as an accept keeps out_valid high with the new result.
        if (loadResult) begin
            outValid_d = 1'b1;
            outClass_d = mergeIdx;
            outMax_d   = mergeMax;
`ifdef FC_ARGMAX_MARGIN_EN
            outMargin_d = mergeMargin;
`endif
        end else if (outValid_q && out_ready) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q       <= IDLE;
            beatCnt_q     <= '0;
            runMax_q      <= '0;
            runIdx_q      <= '0;
            outValid_q    <= 1'b0;
            outClass_q    <= '0;
            outMax_q      <= '0;
            outOverflow_q <= 1'b0;
`ifdef FC_ARGMAX_MARGIN_EN
            runSecond_q <= '0;
            outMargin_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            beatCnt_q     <= beatCnt_d;
            runMax_q      <= runMax_d;
            runIdx_q      <= runIdx_d;
            outValid_q    <= outValid_d;
            outClass_q    <= outClass_d;
            outMax_q      <= outMax_d;
            outOverflow_q <= outOverflow_d;
`ifdef FC_ARGMAX_MARGIN_EN
            runSecond_q <= runSecond_d;
            outMargin_q <= outMargin_d;
`endif
        end
    end

    assign out_valid    = outValid_q;
    assign out_class    = outClass_q;
    assign out_max      = outMax_q;
    assign out_overflow = outOverflow_q;
`ifdef FC_ARGMAX_MARGIN_EN
    assign out_margin   = outMargin_q;
`endif

endmodule

// File: tb/tb_fc_argmax_collector.sv
// Self-checking bench for fc_argmax_collector: directed vector table, hand-written
// corner sequences and randomized traffic against an image-level reference model.
module tb_fc_argmax_collector;

    localparam int BitSize    = 32;
    localparam int Lanes      = 2;
    localparam int Beats      = 4;
    localparam int NumClasses = Lanes * Beats;

    logic                            clk = 1'b0;
    logic                            resN = 1'b0;
    logic                            inValid = 1'b0;
    logic                            inClear = 1'b0;
    logic                            outReady = 1'b0;
    logic [Lanes-1:0][BitSize-1:0]   inData = '0;
    logic                            outValid;
    logic [2:0]                      outClass;
    logic [BitSize-1:0]              outMax;
    logic                            outOverflow;
`ifdef FC_ARGMAX_MARGIN_EN
    logic [BitSize-1:0]              outMargin;
`endif

    int checks = 0;
    int failures = 0;
    int validCycles = 0;

    // Reference model state: scores of the image in progress and the result register contents.
    int          mBeat;
    int          mScores[NumClasses];
    logic        mValid;
    int          mClass;
    int          mMax;
    logic        mOvf;
    logic [31:0] mMargin;

    typedef struct {
        logic v;
        int   d0;
        int   d1;
        logic clr;
        logic rdy;
        logic eValid;
        int   eClass;
        int   eMax;
        logic eOvf;
        int   eMargin;
    } vec_t;

    vec_t vecs[$];

    fc_argmax_collector #(
        .BitSize(BitSize),
        .LanesPerBeat(Lanes),
        .BeatsPerImage(Beats)
    ) dut (
        .clk(clk),
        .res_n(resN),
        .in_valid(inValid),
        .in_data(inData),
        .in_clear(inClear),
        .out_ready(outReady),
        .out_valid(outValid),
        .out_class(outClass),
        .out_max(outMax),
`ifdef FC_ARGMAX_MARGIN_EN
        .out_margin(outMargin),
`endif
        .out_overflow(outOverflow)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkVec(logic v, int d0, int d1, logic clr, logic rdy,
                                   logic eValid, int eClass, int eMax, logic eOvf, int eMargin);
        vec_t t;
        t.v = v; t.d0 = d0; t.d1 = d1; t.clr = clr; t.rdy = rdy;
        t.eValid = eValid; t.eClass = eClass; t.eMax = eMax; t.eOvf = eOvf; t.eMargin = eMargin;
        return t;
    endfunction

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic resetModel();
        mBeat = 0;
        mValid = 1'b0;
        mClass = 0;
        mMax = 0;
        mOvf = 1'b0;
        mMargin = '0;
        foreach (mScores[i]) mScores[i] = 0;
    endtask

    // Image-level rules: argmax with lowest-index ties, margin from the sorted score list.
    task automatic modelStep(input logic v, input int d0, input int d1, input logic clr, input logic rdy);
        logic loaded;
        logic accepted;
        int best;
        int bestIdx;
        int q[$];
        loaded = 1'b0;
        accepted = mValid && rdy;
        if (clr) begin
            mBeat = 0;
            mOvf = 1'b0;
        end else if (v) begin
            mScores[mBeat*Lanes]   = d0;
            mScores[mBeat*Lanes+1] = d1;
            if (mBeat == Beats - 1) begin
                best = mScores[0];
                bestIdx = 0;
                for (int i = 1; i < NumClasses; i++) begin
                    if (mScores[i] > best) begin
                        best = mScores[i];
                        bestIdx = i;
                    end
                end
                q = {};
                foreach (mScores[i]) q.push_back(mScores[i]);
                q.rsort();
                if (!mValid || rdy) begin
                    mValid = 1'b1;
                    mClass = bestIdx;
                    mMax = best;
                    mMargin = 32'(longint'(q[0]) - longint'(q[1]));
                    loaded = 1'b1;
                end else begin
                    mOvf = 1'b1;
                end
                mBeat = 0;
            end else begin
                mBeat++;
            end
        end
        if (accepted && !loaded) mValid = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        checkField({tag, ".valid"}, 32'(outValid), 32'(mValid));
        checkField({tag, ".class"}, 32'(outClass), 32'(mClass));
        checkField({tag, ".max"}, outMax, 32'(mMax));
        checkField({tag, ".overflow"}, 32'(outOverflow), 32'(mOvf));
`ifdef FC_ARGMAX_MARGIN_EN
        checkField({tag, ".margin"}, outMargin, mMargin);
`endif
    endtask

    task automatic driveInputs(input logic v, input int d0, input int d1, input logic clr, input logic rdy);
        @(negedge clk);
        inValid = v;
        inData[0] = d0;
        inData[1] = d1;
        inClear = clr;
        outReady = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input string tag, input logic v, input int d0, input int d1,
                                 input logic clr, input logic rdy);
        driveInputs(v, d0, d1, clr, rdy);
        modelStep(v, d0, d1, clr, rdy);
        if (outValid) validCycles++;
        checkOutput(tag);
    endtask

    task automatic applyVector(input int idx, input vec_t t);
        string tag;
        tag = $sformatf("vec%0d", idx);
        driveInputs(t.v, t.d0, t.d1, t.clr, t.rdy);
        checkField({tag, ".valid"}, 32'(outValid), 32'(t.eValid));
        checkField({tag, ".class"}, 32'(outClass), 32'(t.eClass));
        checkField({tag, ".max"}, outMax, 32'(t.eMax));
        checkField({tag, ".overflow"}, 32'(outOverflow), 32'(t.eOvf));
`ifdef FC_ARGMAX_MARGIN_EN
        checkField({tag, ".margin"}, outMargin, 32'(t.eMargin));
`endif
    endtask

    task automatic doReset();
        @(negedge clk);
        resN = 1'b0;
        inValid = 1'b0;
        inClear = 1'b0;
        outReady = 1'b0;
        inData = '0;
        resetModel();
        repeat (3) @(negedge clk);
        resN = 1'b1;
    endtask

    function automatic int randScore();
        if ($urandom_range(0, 3) == 0) return int'($urandom());
        return int'($urandom_range(0, 8)) - 4;
    endfunction

    initial begin
        // Reset state, then the directed images: ties, negatives, back-pressure with overflow and clear.
        vecs.push_back(mkVec(0,  0,  0, 0, 0, 0, 0,  0, 0, 0));
        vecs.push_back(mkVec(0,  0,  0, 0, 1, 0, 0,  0, 0, 0));
        vecs.push_back(mkVec(1,  5, -3, 0, 1, 0, 0,  0, 0, 0));
        vecs.push_back(mkVec(1,  7,  2, 0, 1, 0, 0,  0, 0, 0));
        vecs.push_back(mkVec(1, -8,  7, 0, 1, 0, 0,  0, 0, 0));
        vecs.push_back(mkVec(1,  1,  0, 0, 1, 1, 2,  7, 0, 0));
        vecs.push_back(mkVec(0,  0,  0, 0, 1, 0, 2,  7, 0, 0));
        vecs.push_back(mkVec(1, -10, -10, 0, 1, 0, 2, 7, 0, 0));
        vecs.push_back(mkVec(1, -10, -10, 0, 1, 0, 2, 7, 0, 0));
        vecs.push_back(mkVec(1, -10, -10, 0, 1, 0, 2, 7, 0, 0));
        vecs.push_back(mkVec(1, -2, -10, 0, 1, 1, 6, -2, 0, 8));
        vecs.push_back(mkVec(0,  0,  0, 0, 1, 0, 6, -2, 0, 8));
        vecs.push_back(mkVec(1,  1,  2, 0, 0, 0, 6, -2, 0, 8));
        vecs.push_back(mkVec(1,  3,  4, 0, 0, 0, 6, -2, 0, 8));
        vecs.push_back(mkVec(1,  5,  6, 0, 0, 0, 6, -2, 0, 8));
        vecs.push_back(mkVec(1,  7,  8, 0, 0, 1, 7,  8, 0, 1));
        vecs.push_back(mkVec(1, 100, 0, 0, 0, 1, 7,  8, 0, 1));
        vecs.push_back(mkVec(1,  0,  0, 0, 0, 1, 7,  8, 0, 1));
        vecs.push_back(mkVec(1,  0,  0, 0, 0, 1, 7,  8, 0, 1));
        vecs.push_back(mkVec(1,  0,  0, 0, 0, 1, 7,  8, 1, 1));
        vecs.push_back(mkVec(0,  0,  0, 1, 0, 1, 7,  8, 0, 1));
        vecs.push_back(mkVec(0,  0,  0, 0, 1, 0, 7,  8, 0, 1));

        $display("[TB] starting");
        resetModel();
        repeat (2) @(negedge clk);
        resN = 1'b1;
        for (int i = 0; i < vecs.size(); i++) applyVector(i, vecs[i]);

        // Accept and load at the same edge: new result replaces the old one, no overflow.
        doReset();
        applyStimulus("simA", 1, 1, 2, 0, 0);
        applyStimulus("simA", 1, 3, 4, 0, 0);
        applyStimulus("simA", 1, 5, 6, 0, 0);
        applyStimulus("simA", 1, 7, 8, 0, 0);
        applyStimulus("simB", 1, 100, 0, 0, 0);
        applyStimulus("simB", 1, 0, 0, 0, 0);
        applyStimulus("simB", 1, 0, 0, 0, 0);
        applyStimulus("simB", 1, 0, 0, 0, 1);
        checkField("simLoad.valid", 32'(outValid), 32'd1);
        checkField("simLoad.class", 32'(outClass), 32'd0);
        checkField("simLoad.max", outMax, 32'd100);
        checkField("simLoad.overflow", 32'(outOverflow), 32'd0);
        applyStimulus("simDrain", 0, 0, 0, 0, 1);

        // Abort by clear colliding with a beat: only the fresh image produces a result.
        doReset();
        validCycles = 0;
        applyStimulus("abort", 1, 50, 1, 0, 1);
        applyStimulus("abort", 1, 2, 3, 0, 1);
        applyStimulus("abort", 1, 99, 99, 1, 1);
        applyStimulus("abort", 1, -1, -2, 0, 1);
        applyStimulus("abort", 1, -3, 4, 0, 1);
        applyStimulus("abort", 1, 0, -5, 0, 1);
        applyStimulus("abort", 1, 3, -7, 0, 1);
        applyStimulus("abort", 0, 0, 0, 0, 1);
        applyStimulus("abort", 0, 0, 0, 0, 1);
        checkField("abort.results", 32'(validCycles), 32'd1);
        checkField("abort.class", 32'(outClass), 32'd3);
        checkField("abort.max", outMax, 32'd4);

        // Reset mid-image discards the partial image the same way.
        doReset();
        validCycles = 0;
        applyStimulus("rstMid", 1, 80, 81, 0, 1);
        applyStimulus("rstMid", 1, 82, 83, 0, 1);
        doReset();
        applyStimulus("rstMid", 1, -1, -2, 0, 1);
        applyStimulus("rstMid", 1, -3, 4, 0, 1);
        applyStimulus("rstMid", 1, 0, -5, 0, 1);
        applyStimulus("rstMid", 1, 3, -7, 0, 1);
        applyStimulus("rstMid", 0, 0, 0, 0, 1);
        applyStimulus("rstMid", 0, 0, 0, 0, 1);
        checkField("rstMid.results", 32'(validCycles), 32'd1);
        checkField("rstMid.class", 32'(outClass), 32'd3);

        // Randomized traffic with narrow score ranges so ties are frequent.
        doReset();
        for (int c = 0; c < 3000; c++) begin
            applyStimulus($sformatf("rnd%0d", c),
                          logic'($urandom_range(0, 3) != 0),
                          randScore(), randScore(),
                          logic'($urandom_range(0, 31) == 0),
                          logic'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
